// File: rtl/mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Operand width, counter width and the controller state encoding.
package mul_pkg;

    localparam int MUL_W = 32;
    localparam int CNT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/adder_nbit.sv
// W-bit ripple-carry adder with carry-out.
// Carry-in is fixed at zero.
module adder_nbit #(
    parameter int W = 32
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         co_o
);

    always_comb begin
        logic cy;
        cy    = 1'b0;
        sum_o = '0;
        for (int i = 0; i < W; i++) begin
            sum_o[i] = a_i[i] ^ b_i[i] ^ cy;
            cy       = (a_i[i] & b_i[i]) | (cy & (a_i[i] ^ b_i[i]));
        end
        co_o = cy;
    end

endmodule

// File: rtl/multiplier_seq.sv
// Unsigned W x W -> 2W shift-and-add multiplier, one multiplier bit per clock.
// start/busy/done handshake shared with the restoring divider controller.
module multiplier_seq
    import mul_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  logic           clk,
    input  logic           r,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    state_e             state_q;
    logic [W-1:0]       m_q;
    logic [2*W-1:0]     p_q;
    logic [2*W-1:0]     p_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [W-1:0]       addend_s;
    logic [W-1:0]       sum_s;
    logic               co_s;
    logic               last_s;

    assign addend_s = p_q[0] ? m_q : '0;

    adder_nbit #(.W(W)) u_add (
        .a_i   (p_q[2*W-1:W]),
        .b_i   (addend_s),
        .sum_o (sum_s),
        .co_o  (co_s)
    );

    // Carry re-enters at the top so the full 2W-bit product never overflows
    assign p_d    = {co_s, sum_s, p_q[W-1:1]};
    assign last_s = (cnt_q == CNT_W'(W - 1));

    always_ff @(posedge clk) begin
        if (r) begin
            state_q <= IDLE;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        m_q     <= a;
                        p_q     <= {{W{1'b0}}, b};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    p_q   <= p_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_s) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = p_q;

endmodule

// File: tb/tb_multiplier_seq.sv
// Directed bench for multiplier_seq: vector table plus handshake corner cases.
// Expected products and cycle numbers are hand-computed constants.
module tb_multiplier_seq;

    logic        clk;
    logic        r;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] p;
    } vec_t;

    vec_t vecs [8];

    multiplier_seq #(.W(32)) dut (
        .clk     (clk),
        .r       (r),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: act=0x%0h req=0x%0h", nm, act, exp);
        end
    endtask

    task automatic do_mul(input logic [31:0] av, input logic [31:0] bv,
                          input logic [63:0] ep, input string nm);
        int cyc;
        int bc;
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~av;
        b     = ~bv;
        cyc   = 1;
        bc    = 0;
        while (!done && cyc < 50) begin
            if (busy) bc++;
            tick();
            cyc++;
        end
        chk({nm, " latency"}, 64'(cyc), 64'd33);
        chk({nm, " busy_cycles"}, 64'(bc), 64'd32);
        chk({nm, " busy_at_done"}, 64'(busy), 64'd0);
        chk({nm, " product"}, product, ep);
        tick();
        chk({nm, " done_pulse"}, 64'(done), 64'd0);
        chk({nm, " held"}, product, ep);
    endtask

    initial begin
        int cyc;
        int nd;
        int dcyc [3];
        logic prev;

        n_cmp = 0;
        n_bad = 0;
        r     = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;

        vecs[0] = '{32'd31,        32'd108,        64'd3348};
        vecs[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001};
        vecs[2] = '{32'd0,         32'hDEADBEEF, 64'd0};
        vecs[3] = '{32'd1,         32'hFFFFFFFF, 64'h00000000FFFFFFFF};
        vecs[4] = '{32'hFFFFFFFF, 32'd2,         64'h00000001FFFFFFFE};
        vecs[5] = '{32'h00010000, 32'h00010000, 64'h0000000100000000};
        vecs[6] = '{32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[7] = '{32'd5,         32'd6,         64'd30};

        tick();
        tick();
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset product", product, 64'd0);
        r = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            do_mul(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

        // start re-pulsed mid-run must be ignored
        a     = 32'd5;
        b     = 32'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 10) begin
            tick();
            cyc++;
        end
        a     = 32'd7;
        b     = 32'd9;
        start = 1'b1;
        tick();
        cyc++;
        start = 1'b0;
        while (!done && cyc < 50) begin
            tick();
            cyc++;
        end
        chk("repulse latency", 64'(cyc), 64'd33);
        chk("repulse product", product, 64'd30);
        tick();

        // reset mid-run, with start raised alongside it
        a     = 32'h12345678;
        b     = 32'h9ABCDEF0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 12) begin
            tick();
            cyc++;
        end
        chk("midrun busy", 64'(busy), 64'd1);
        r     = 1'b1;
        start = 1'b1;
        tick();
        chk("rst product", product, 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        r     = 1'b0;
        start = 1'b0;
        tick();
        chk("rst start dropped", 64'(busy), 64'd0);
        do_mul(32'd3, 32'd4, 64'd12, "after_rst");

        // start held high: back-to-back issue every W+2 cycles
        a     = 32'd2;
        b     = 32'd3;
        start = 1'b1;
        tick();
        cyc  = 1;
        nd   = 0;
        prev = 1'b0;
        while (cyc <= 105) begin
            chk("held excl", 64'(busy & done), 64'd0);
            chk("held width", 64'(done & prev), 64'd0);
            if (done) begin
                if (nd < 3) dcyc[nd] = cyc;
                nd++;
                chk("held product", product, 64'd6);
            end
            prev = done;
            if (cyc == 100) start = 1'b0;
            tick();
            cyc++;
        end
        chk("held count", 64'(nd), 64'd3);
        chk("held done1", 64'(dcyc[0]), 64'd33);
        chk("held done2", 64'(dcyc[1]), 64'd67);
        chk("held done3", 64'(dcyc[2]), 64'd101);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
